// File: rtl/cnt_diff_decoder.sv
// Decodes {msb, lsb} split-counter samples into elapsed counts since the previous sample.
// Optional saturating reject counter on err_cnt_o when CNT_DIFF_ERR_CNT_EN is defined.
module cnt_diff_decoder #(
    parameter int LSB_W       = 12,
    parameter int MSB_W       = 3,
    parameter int LSB_CNT_MAX = 3563,
    parameter int DIFF_W      = LSB_W + MSB_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [LSB_W-1:0]  lsb_cnt_i,
    input  logic [MSB_W-1:0]  msb_cnt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DIFF_W-1:0] diff_o,
`ifdef CNT_DIFF_ERR_CNT_EN
    output logic [7:0]        err_cnt_o,
`endif
    output logic              lsb_cnt_err_o
);

    localparam int PW = DIFF_W + 1;
    localparam int P  = LSB_CNT_MAX + 1;
    localparam logic [PW-1:0] LP_P     = PW'(P);
    localparam logic [PW-1:0] LP_TOTAL = PW'(P * (2 ** MSB_W));

    typedef enum logic {
        ST_FIRST,
        ST_TRACK
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LSB_W-1:0]  r_prev_lsb;
    logic [MSB_W-1:0]  r_prev_msb;
    logic              r_out_valid;
    logic [DIFF_W-1:0] r_diff;
    logic              r_err;

    logic              w_acc;
    logic              w_legal;
    logic [PW-1:0]     w_new_pos;
    logic [PW-1:0]     w_prev_pos;
    logic [PW-1:0]     w_fwd;
    logic [PW-1:0]     w_wrap;
    logic [DIFF_W-1:0] w_diff;
    logic              w_load_prev;
    logic              w_load_diff;
    logic              w_ov_nxt;

    assign in_ready_o    = !r_out_valid | out_ready_i;
    assign w_acc         = in_valid_i & in_ready_o;
    assign w_legal       = (lsb_cnt_i <= LSB_W'(LSB_CNT_MAX));
    assign out_valid_o   = r_out_valid;
    assign diff_o        = r_diff;
    assign lsb_cnt_err_o = r_err;

    // Linear positions carry one spare bit so the wrap sum cannot overflow.
    assign w_new_pos  = PW'(msb_cnt_i) * LP_P + PW'(lsb_cnt_i);
    assign w_prev_pos = PW'(r_prev_msb) * LP_P + PW'(r_prev_lsb);
    assign w_fwd      = w_new_pos - w_prev_pos;
    assign w_wrap     = w_new_pos + LP_TOTAL - w_prev_pos;
    assign w_diff     = DIFF_W'((w_new_pos >= w_prev_pos) ? w_fwd : w_wrap);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = ST_FIRST;
        end else if (w_acc && w_legal) begin
            w_state_nxt = ST_TRACK;
        end
    end

    always_comb begin
        w_load_prev = 1'b0;
        w_load_diff = 1'b0;
        w_ov_nxt    = r_out_valid;
        if (clear_i) begin
            w_ov_nxt = 1'b0;
        end else if (w_acc) begin
            w_load_prev = w_legal;
            w_load_diff = w_legal && (r_state == ST_TRACK);
            w_ov_nxt    = w_load_diff;
        end else if (out_ready_i) begin
            w_ov_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prev_lsb  <= '0;
            r_prev_msb  <= '0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_ov_nxt;
            r_err       <= w_acc & !w_legal;
            if (w_load_prev) begin
                r_prev_lsb <= lsb_cnt_i;
                r_prev_msb <= msb_cnt_i;
            end
            if (w_load_diff) begin
                r_diff <= w_diff;
            end
        end
    end

`ifdef CNT_DIFF_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    assign err_cnt_o = r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_cnt <= '0;
        end else if (clear_i) begin
            r_err_cnt <= '0;
        end else if (w_acc && !w_legal && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cnt_diff_decoder.sv
// Bench for cnt_diff_decoder: directed vector table, reset/clear sequences,
// then random traffic against a position-arithmetic reference model.
module tb_cnt_diff_decoder;

    localparam int P     = 3564;
    localparam int TOTAL = P * 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        clear_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] lsb_cnt_i;
    logic [2:0]  msb_cnt_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [14:0] diff_o;
    logic        lsb_cnt_err_o;
`ifdef CNT_DIFF_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    cnt_diff_decoder dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .clear_i(clear_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .lsb_cnt_i(lsb_cnt_i),
        .msb_cnt_i(msb_cnt_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .diff_o(diff_o),
`ifdef CNT_DIFF_ERR_CNT_EN
        .err_cnt_o(err_cnt_o),
`endif
        .lsb_cnt_err_o(lsb_cnt_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit v;
        int m;
        int l;
        bit c;
        bit r;
        bit ov;
        int d;
        bit e;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_have;
    int m_prev;
    bit m_ov;
    int m_diff;
    bit m_err;
    int m_ecnt;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0;
        m_prev = 0;
        m_ov   = 0;
        m_diff = 0;
        m_err  = 0;
        m_ecnt = 0;
    endtask

    task automatic model_edge(input bit v, input int m, input int l,
                              input bit c, input bit r);
        bit acc;
        bit legal;
        int pos;
        acc   = v && (!m_ov || r);
        legal = (l <= P - 1);
        pos   = m * P + l;
        m_err = acc && !legal;
        if (c) begin
            m_have = 0;
            m_ov   = 0;
            m_ecnt = 0;
        end else begin
            if (acc && !legal && m_ecnt < 255) m_ecnt++;
            if (acc && legal) begin
                if (m_have) begin
                    m_diff = (pos - m_prev + TOTAL) % TOTAL;
                    m_ov   = 1;
                end else begin
                    m_ov = 0;
                end
                m_prev = pos;
                m_have = 1;
            end else if (acc || r) begin
                m_ov = 0;
            end
        end
    endtask

    task automatic step(input bit v, input int m, input int l,
                        input bit c, input bit r);
        in_valid_i  = v;
        msb_cnt_i   = m[2:0];
        lsb_cnt_i   = l[11:0];
        clear_i     = c;
        out_ready_i = r;
        #1;
        chk("in_ready", int'(in_ready_o), int'(!m_ov || r));
        @(posedge clk_i);
        model_edge(v, m, l, c, r);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ov"}, int'(out_valid_o), int'(m_ov));
        chk({tag, "_diff"}, int'(diff_o), m_diff);
        chk({tag, "_err"}, int'(lsb_cnt_err_o), int'(m_err));
`ifdef CNT_DIFF_ERR_CNT_EN
        chk({tag, "_ecnt"}, int'(err_cnt_o), m_ecnt);
`endif
    endtask

    task automatic add(input bit v, input int m, input int l, input bit c,
                       input bit r, input bit ov, input int d, input bit e);
        vec_t x;
        x.v = v; x.m = m; x.l = l; x.c = c; x.r = r;
        x.ov = ov; x.d = d; x.e = e;
        tbl.push_back(x);
    endtask

    initial begin
        add(0, 0, 0,    0, 1, 0, 0,     0);
        add(1, 0, 100,  0, 1, 0, 0,     0);
        add(1, 0, 350,  0, 1, 1, 250,   0);
        add(0, 0, 0,    0, 1, 0, 250,   0);
        add(1, 7, 3500, 0, 1, 1, 28098, 0);
        add(1, 0, 10,   0, 1, 1, 74,    0);
        add(1, 2, 3563, 0, 1, 1, 10681, 0);
        add(1, 3, 0,    0, 1, 1, 1,     0);
        add(1, 1, 5,    0, 1, 1, 21389, 0);
        add(1, 1, 3600, 0, 1, 0, 21389, 1);
        add(1, 1, 9,    0, 1, 1, 4,     0);
        add(1, 0, 100,  0, 1, 1, 25039, 0);
        add(1, 0, 350,  0, 1, 1, 250,   0);
        add(1, 0, 700,  0, 0, 1, 250,   0);
        add(1, 0, 700,  0, 0, 1, 250,   0);
        add(1, 0, 700,  0, 1, 1, 350,   0);
        add(1, 4, 1000, 0, 1, 1, 14556, 0);
        add(1, 4, 1000, 0, 1, 1, 0,     0);
        add(0, 0, 0,    1, 0, 0, 0,     0);
        add(1, 0, 100,  0, 1, 0, 0,     0);
        add(1, 0, 200,  0, 1, 1, 100,   0);
        add(1, 0, 4000, 1, 1, 0, 100,   1);
        add(1, 0, 300,  0, 1, 0, 100,   0);
        add(1, 0, 301,  0, 1, 1, 1,     0);

        rst_n_i     = 1'b0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        lsb_cnt_i   = '0;
        msb_cnt_i   = '0;
        out_ready_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ov", int'(out_valid_o), 0);
        chk("rst_diff", int'(diff_o), 0);
        chk("rst_err", int'(lsb_cnt_err_o), 0);
        chk("rst_ready", int'(in_ready_o), 1);
        rst_n_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].m, tbl[i].l, tbl[i].c, tbl[i].r);
            chk($sformatf("vec%0d_ov", i), int'(out_valid_o), int'(tbl[i].ov));
            chk($sformatf("vec%0d_diff", i), int'(diff_o), tbl[i].d);
            chk($sformatf("vec%0d_err", i), int'(lsb_cnt_err_o), int'(tbl[i].e));
        end

        // Async reset mid-stream with an output pending
        step(1, 0, 500, 0, 0);
        chk("pre_rst_ov", int'(out_valid_o), 1);
        rst_n_i = 1'b0;
        #1;
        chk("arst_ov", int'(out_valid_o), 0);
        chk("arst_diff", int'(diff_o), 0);
        chk("arst_ready", int'(in_ready_o), 1);
        model_reset();
        #1;
        rst_n_i = 1'b1;
        step(1, 0, 50, 0, 1);
        chk("post_rst_first_ov", int'(out_valid_o), 0);
        step(1, 0, 60, 0, 1);
        chk("post_rst_ov", int'(out_valid_o), 1);
        chk("post_rst_diff", int'(diff_o), 10);

        // Error pulse width and counter through two rejects
        step(1, 5, 4095, 0, 1);
        chk_model("err1");
        step(1, 5, 3700, 0, 1);
        chk_model("err2");
        step(0, 0, 0, 0, 1);
        chk("err_pulse_end", int'(lsb_cnt_err_o), 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7),
                 $urandom_range(0, 3700), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7);
            chk_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
